// File: rtl/sdf_unit2_rotate_pkg.sv
// Shared types, twiddle ROM and complex multiplier for the R2SDF FFT stages.
// Latency: none (combinational helpers only).
// Backpressure: none; used inside the enable-driven stage datapath.
package sdf_unit2_rotate_pkg;

  localparam int DATA_IN_WIDTH = 16;
  localparam int TW_FRAC       = 14;
  localparam int TW_WIDTH      = TW_FRAC + 2;
  // Largest FFT size whose twiddles the ROM can serve; a stage needs D<<FFT_STAGE <= N_MAX.
  localparam int N_MAX         = 32;
  localparam int TW_IDX_W      = $clog2(N_MAX / 2);
  // Delay lines at least this deep use a pointer-addressed memory instead of a register chain.
  localparam int DL_RAM_MIN    = 8;

  typedef logic signed [DATA_IN_WIDTH-1:0] samp_t;
  typedef logic signed [TW_WIDTH-1:0]      coef_t;
  typedef struct packed { samp_t re; samp_t im; } cplx_t;
  typedef struct packed { coef_t re; coef_t im; } tw_t;

  // First quadrant of cos(2*pi*i/N_MAX) in Q2.14, i = 0..N_MAX/4.
  function automatic coef_t tw_quarter(input int i);
    case (i)
      0:       tw_quarter = 16'sd16384;
      1:       tw_quarter = 16'sd16069;
      2:       tw_quarter = 16'sd15137;
      3:       tw_quarter = 16'sd13623;
      4:       tw_quarter = 16'sd11585;
      5:       tw_quarter = 16'sd9102;
      6:       tw_quarter = 16'sd6270;
      7:       tw_quarter = 16'sd3196;
      default: tw_quarter = 16'sd0;
    endcase
  endfunction

  // W_NMAX^idx = cos - j*sin over the half circle, folded from the quarter table.
  function automatic tw_t twiddle_rom(input logic [TW_IDX_W-1:0] idx);
    int    i;
    coef_t c;
    coef_t s;
    i = int'(idx);
    if (i <= N_MAX / 4) begin
      c = tw_quarter(i);
      s = tw_quarter(N_MAX / 4 - i);
    end else begin
      c = -tw_quarter(N_MAX / 2 - i);
      s = tw_quarter(i - N_MAX / 4);
    end
    twiddle_rom.re = c;
    twiddle_rom.im = -s;
  endfunction

  // x*w with Q2.14 coefficients; floor shift, then keep the low DATA_IN_WIDTH bits.
  function automatic cplx_t cmul(input cplx_t x, input tw_t w);
    logic signed [31:0] xr, xi, wr, wi, p_re, p_im;
    xr   = {{(32-DATA_IN_WIDTH){x.re[DATA_IN_WIDTH-1]}}, x.re};
    xi   = {{(32-DATA_IN_WIDTH){x.im[DATA_IN_WIDTH-1]}}, x.im};
    wr   = {{(32-TW_WIDTH){w.re[TW_WIDTH-1]}}, w.re};
    wi   = {{(32-TW_WIDTH){w.im[TW_WIDTH-1]}}, w.im};
    p_re = (xr * wr - xi * wi) >>> TW_FRAC;
    p_im = (xr * wi + xi * wr) >>> TW_FRAC;
    cmul.re = p_re[DATA_IN_WIDTH-1:0];
    cmul.im = p_im[DATA_IN_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/sdf_unit2_rotate_delay_line.sv
// Feedback delay: dout_o is the word written DEPTH enabled cycles ago.
// Latency: DEPTH enabled cycles.
// Backpressure: none; contents freeze while en_i is low.
module sdf_unit2_rotate_delay_line #(
  parameter int DEPTH   = 1,
  parameter int WIDTH   = 32,
  parameter int RAM_MIN = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  if (DEPTH < RAM_MIN) begin : g_chain
    logic [WIDTH-1:0] chain_q [DEPTH];
    logic             unused_rstn;
    assign unused_rstn = rstn;

    // Shift the chain by one word per enabled cycle; contents are never cleared.
    always_ff @(posedge clk) begin
      if (en_i) begin
        chain_q[0] <= din_i;
        for (int i = 1; i < DEPTH; i++) chain_q[i] <= chain_q[i-1];
      end
    end
    assign dout_o = chain_q[DEPTH-1];
  end else begin : g_ram
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ptr_q;

    // Read-before-write at the same slot gives exactly DEPTH words of delay.
    assign dout_o = mem_q[ptr_q];

    // Memory write at the circular pointer.
    always_ff @(posedge clk) begin
      if (en_i) mem_q[ptr_q] <= din_i;
    end

    // Pointer advances per enabled cycle; only the pointer is reset.
    always_ff @(posedge clk) begin
      if (!rstn)     ptr_q <= '0;
      else if (en_i) ptr_q <= ptr_q + AW'(1);
    end
  end

endmodule

// File: rtl/sdf_unit2_rotate.sv
// One radix-2 SDF DIF stage: butterfly, D-deep feedback delay, W_2D^k rotation.
// Latency: 2 clocks from an enabled input cycle to its output.
// Backpressure: none; di_en=0 freezes counter/delay, the output pipe keeps draining.
module sdf_unit2_rotate
  import sdf_unit2_rotate_pkg::*;
#(
  parameter int DELAY_DEPTH = 1,
  parameter int FFT_STAGE   = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     di_en,
  input  logic [DATA_IN_WIDTH-1:0] di_re,
  input  logic [DATA_IN_WIDTH-1:0] di_im,
  output logic                     do_en,
  output logic [DATA_IN_WIDTH-1:0] do_re,
  output logic [DATA_IN_WIDTH-1:0] do_im
);

  localparam int D     = DELAY_DEPTH;
  localparam int CW    = $clog2(2 * D);
  localparam int FFT_N = D << FFT_STAGE;
  // ROM stride so that entry k*TW_STEP of the N_MAX table is W_N^(k*2^(FFT_STAGE-1)) = W_2D^k.
  localparam int TW_STEP = (N_MAX / FFT_N) << (FFT_STAGE - 1);

  logic [CW-1:0]       cnt_q, cnt_d, k_full;
  logic                primed_q, primed_d;
  logic                phase1;
  logic [TW_IDX_W-1:0] tw_idx;
  cplx_t               din, head, dl_din, bfly_sum, bfly_diff;
  logic signed [DATA_IN_WIDTH:0] a_re, a_im, b_re, b_im, s_re, s_im, d_re, d_im;

  cplx_t s1_dat_q, s1_dat_d;
  tw_t   s1_tw_q, s1_tw_d;
  logic  s1_byp_q, s1_byp_d, s1_vld_q, s1_vld_d;
  cplx_t do_dat_q, do_dat_d;
  logic  do_en_q, do_en_d;

  assign din    = {di_re, di_im};
  assign phase1 = cnt_q[CW-1];
  // k is the position inside the half block; masking also yields k=0 for D=1.
  assign k_full = cnt_q & CW'(D - 1);
  assign tw_idx = TW_IDX_W'(int'(k_full) * TW_STEP);

  // Butterfly at one extra bit; dropping bit 0 is a floor divide by two.
  assign a_re = {head.re[DATA_IN_WIDTH-1], head.re};
  assign a_im = {head.im[DATA_IN_WIDTH-1], head.im};
  assign b_re = {din.re[DATA_IN_WIDTH-1], din.re};
  assign b_im = {din.im[DATA_IN_WIDTH-1], din.im};
  assign s_re = a_re + b_re;
  assign s_im = a_im + b_im;
  assign d_re = a_re - b_re;
  assign d_im = a_im - b_im;
  assign bfly_sum  = {s_re[DATA_IN_WIDTH:1], s_im[DATA_IN_WIDTH:1]};
  assign bfly_diff = {d_re[DATA_IN_WIDTH:1], d_im[DATA_IN_WIDTH:1]};

  // Phase 0 stores the raw sample, phase 1 stores the difference for the next block.
  assign dl_din = phase1 ? bfly_diff : din;

  sdf_unit2_rotate_delay_line #(
    .DEPTH   (D),
    .WIDTH   (2 * DATA_IN_WIDTH),
    .RAM_MIN (DL_RAM_MIN)
  ) u_delay (
    .clk    (clk),
    .rstn   (rstn),
    .en_i   (di_en),
    .din_i  (dl_din),
    .dout_o (head)
  );

  // Next state: phase counter, primed flag and stage-1 capture of mux result plus twiddle.
  always_comb begin
    cnt_d    = di_en ? cnt_q + CW'(1) : cnt_q;
    primed_d = primed_q | (di_en & phase1);
    s1_vld_d = di_en & (phase1 | primed_q);
    s1_dat_d = s1_dat_q;
    s1_tw_d  = s1_tw_q;
    s1_byp_d = s1_byp_q;
    if (di_en) begin
      s1_dat_d = phase1 ? bfly_sum : head;
      s1_tw_d  = twiddle_rom(tw_idx);
      s1_byp_d = phase1 | (tw_idx == '0);
    end
  end

  // Stage 2: rotate (or pass exactly) and hold the last value when nothing is valid.
  always_comb begin
    do_en_d  = s1_vld_q;
    do_dat_d = do_dat_q;
    if (s1_vld_q) do_dat_d = s1_byp_q ? s1_dat_q : cmul(s1_dat_q, s1_tw_q);
  end

  // State registers with synchronous active-low reset; delay-line contents are not cleared.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
      s1_dat_q <= '0;
      s1_tw_q  <= '0;
      s1_byp_q <= 1'b0;
      s1_vld_q <= 1'b0;
      do_dat_q <= '0;
      do_en_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      s1_dat_q <= s1_dat_d;
      s1_tw_q  <= s1_tw_d;
      s1_byp_q <= s1_byp_d;
      s1_vld_q <= s1_vld_d;
      do_dat_q <= do_dat_d;
      do_en_q  <= do_en_d;
    end
  end

  assign do_en = do_en_q;
  assign do_re = do_dat_q.re;
  assign do_im = do_dat_q.im;

endmodule

// File: tb/tb_sdf_unit2_rotate.sv
// Scoreboard bench driving D=1, D=2 and D=4 stages with a shared input stream.
// Latency: expected entries carry the clock on which they must appear.
// Backpressure: random di_en gaps; outputs must hold while do_en is low.
module tb_sdf_unit2_rotate;

  localparam int NI = 3;

  typedef struct {
    int re;
    int im;
    int due;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic                    di_en = 1'b0;
  logic [15:0]             di_re = '0;
  logic [15:0]             di_im = '0;
  logic [NI-1:0]           do_en_w;
  logic [NI-1:0][15:0]     do_re_w;
  logic [NI-1:0][15:0]     do_im_w;
  logic                    rstn_at_edge = 1'b0;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_acc [NI];
  int   x_re [NI][16];
  int   x_im [NI][16];
  int   pd_re [NI][16];
  int   pd_im [NI][16];
  int   last_re [NI];
  int   last_im [NI];
  exp_t sb [NI][$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    rstn_at_edge <= rstn;
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sdf_unit2_rotate #(
      .DELAY_DEPTH (1 << g),
      .FFT_STAGE   (3 - g)
    ) u_dut (
      .clk   (clk),
      .rstn  (rstn),
      .di_en (di_en),
      .di_re (di_re),
      .di_im (di_im),
      .do_en (do_en_w[g]),
      .do_re (do_re_w[g]),
      .do_im (do_im_w[g])
    );
  end

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  // x * exp(-j*2*pi*k/(2d)) with Q2.14 coefficients, floor shift, 16-bit wrap; k=0 exact.
  function automatic void rotate(input int xr, input int xi, input int k, input int d,
                                 output int yr, output int yi);
    real ang;
    int  wr, wi;
    if (k == 0) begin
      yr = xr;
      yi = xi;
      return;
    end
    ang = 2.0 * 3.14159265358979 * k / (2 * d);
    wr  = int'(16384.0 * $cos(ang));
    wi  = -int'(16384.0 * $sin(ang));
    yr  = wrap16((xr * wr - xi * wi) >>> 14);
    yi  = wrap16((xr * wi + xi * wr) >>> 14);
  endfunction

  // Block-level model: first half buffered, second half yields sums now and diffs next block.
  function automatic void accept(input int i, input int re, input int im);
    int   d, p, j, yr, yi;
    exp_t e;
    d     = 1 << i;
    p     = n_acc[i] % (2 * d);
    e.due = cyc + 2;
    if (p < d) begin
      if (n_acc[i] >= d) begin
        rotate(pd_re[i][p], pd_im[i][p], p, d, yr, yi);
        e.re = yr;
        e.im = yi;
        sb[i].push_back(e);
      end
      x_re[i][p] = re;
      x_im[i][p] = im;
    end else begin
      j = p - d;
      e.re = (x_re[i][j] + re) >>> 1;
      e.im = (x_im[i][j] + im) >>> 1;
      sb[i].push_back(e);
      pd_re[i][j] = (x_re[i][j] - re) >>> 1;
      pd_im[i][j] = (x_im[i][j] - im) >>> 1;
    end
    n_acc[i]++;
  endfunction

  task automatic drive(input logic en, input int re, input int im);
    @(posedge clk);
    #1;
    di_en = en;
    di_re = 16'(re);
    di_im = 16'(im);
    if (en) for (int i = 0; i < NI; i++) accept(i, re, im);
  endtask

  // One-cycle reset; entries that would surface at or after the reset edge are lost.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn  = 1'b0;
    di_en = 1'b0;
    for (int i = 0; i < NI; i++) begin
      while (sb[i].size() > 0 && sb[i][$].due > cyc) void'(sb[i].pop_back());
      n_acc[i] = 0;
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (cyc >= 1 && !rstn_at_edge) begin
        checks++;
        if (do_en_w[i] !== 1'b0 || do_re_w[i] !== 16'h0 || do_im_w[i] !== 16'h0) begin
          errors++;
          $display("FAIL reset_clear[%0d] cyc=%0d got en=%b re=%0d im=%0d want 0,0,0",
                   i, cyc, do_en_w[i], $signed(do_re_w[i]), $signed(do_im_w[i]));
        end
        last_re[i] = 0;
        last_im[i] = 0;
      end else if (cyc >= 1 && do_en_w[i]) begin
        checks++;
        if (sb[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_out[%0d] cyc=%0d got re=%0d im=%0d want no output",
                   i, cyc, $signed(do_re_w[i]), $signed(do_im_w[i]));
        end else begin
          mon_e = sb[i].pop_front();
          if (int'($signed(do_re_w[i])) != mon_e.re || int'($signed(do_im_w[i])) != mon_e.im ||
              cyc != mon_e.due) begin
            errors++;
            $display("FAIL sample[%0d] cyc=%0d got (%0d,%0d) want (%0d,%0d) at cyc %0d",
                     i, cyc, $signed(do_re_w[i]), $signed(do_im_w[i]),
                     mon_e.re, mon_e.im, mon_e.due);
          end
          last_re[i] = mon_e.re;
          last_im[i] = mon_e.im;
        end
      end else if (cyc >= 1) begin
        checks++;
        if (int'($signed(do_re_w[i])) != last_re[i] || int'($signed(do_im_w[i])) != last_im[i]) begin
          errors++;
          $display("FAIL hold[%0d] cyc=%0d got (%0d,%0d) want (%0d,%0d)",
                   i, cyc, $signed(do_re_w[i]), $signed(do_im_w[i]), last_re[i], last_im[i]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      n_acc[i]   = 0;
      last_re[i] = 0;
      last_im[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Ramp 0..15, imaginary 0.
    for (int v = 0; v < 16; v++) drive(1'b1, v, 0);
    repeat (3) drive(1'b0, 0, 0);

    // Full-scale pairs exercising the extra butterfly bit.
    drive(1'b1, 32767, 0);   drive(1'b1, 32767, 0);
    drive(1'b1, 32767, 100); drive(1'b1, -32768, -100);
    drive(1'b1, -32768, 32767); drive(1'b1, -32768, 32767);
    drive(1'b1, -32768, -32768); drive(1'b1, 32767, 32767);

    // Impulse then zeros, with a 3-cycle gap mid-block.
    drive(1'b1, 100, 0);
    for (int v = 0; v < 3; v++) drive(1'b1, 0, 0);
    repeat (3) drive(1'b0, 0, 0);
    for (int v = 0; v < 12; v++) drive(1'b1, 0, 0);

    // Random data with random enable gaps.
    for (int v = 0; v < 300; v++) drive($urandom_range(3) != 0, rnd16(), rnd16());

    // Reset in the middle of a block, then a fresh ramp.
    for (int v = 0; v < 3; v++) drive(1'b1, rnd16(), rnd16());
    do_reset();
    for (int v = 0; v < 16; v++) drive(1'b1, v, 0);
    for (int v = 0; v < 100; v++) drive($urandom_range(4) != 0, rnd16(), rnd16());

    repeat (5) drive(1'b0, 0, 0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (sb[i].size() != 0) begin
        errors++;
        $display("FAIL leftover[%0d] got %0d pending outputs want 0", i, sb[i].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
